// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared types and constants for the nonce sweep controller and its helpers.
//   sweep_state_t  : sequencer states
//   NONCE_W        : nonce width (nonce sits in message bits [NONCE_W-1:0])
//   MSG_W          : message width presented to the SHA core
//   DIGEST_W       : SHA digest width
//   MSG_LEN        : constant message length driven to the core
//   TIMEOUT_CYCLES : per-hash watchdog limit (used with NONCE_SWEEP_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int          NONCE_W        = 32;
    localparam int          MSG_W          = 447;
    localparam int          DIGEST_W       = 256;
    localparam logic [63:0] MSG_LEN        = 64'd447;
    localparam int          TIMEOUT_CYCLES = 16383;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/digest_compare.sv
// ---------------------------------------------------------------------------
// digest_compare
// Combinational 256-bit unsigned less-than used to qualify a hit.
//   digest : SHA core output
//   target : latched threshold
//   hit    : 1 when digest < target (unsigned)
// ---------------------------------------------------------------------------
module digest_compare
    import miner_pkg::*;
(
    input  logic [DIGEST_W-1:0] digest,
    input  logic [DIGEST_W-1:0] target,
    output logic                hit
);

    assign hit = (digest < target);

endmodule

// File: rtl/nonce_sweep_controller.sv
// ---------------------------------------------------------------------------
// nonce_sweep_controller
// Owns the SHA core and sweeps an inclusive nonce range through it, stopping
// on the first digest below target, on range exhaustion, or on abort.
//
// Ports:
//   clk, n_rst                 : clock, asynchronous active-low reset
//   start, abort               : host control (start only honoured in IDLE)
//   base_msg, nonce_start,
//   nonce_end, target          : sweep configuration, latched on start
//   sha_msg, sha_length,
//   sha_new_msg, sha_begin     : message and strobes to the SHA core
//   sha_complete, sha_output   : completion level and digest from the core
//   busy, done                 : activity level, one-cycle completion pulse
//   hit, exhausted, timed_out  : sticky result flags (cleared on next start)
//   found_nonce                : nonce that produced the hit
//   hash_count                 : digests checked since start (saturating)
//
// Build option: define NONCE_SWEEP_TIMEOUT_EN to add a per-hash watchdog in
// WAIT; without it WAIT is unbounded and timed_out is tied low.
// ---------------------------------------------------------------------------
module nonce_sweep_controller
    import miner_pkg::*;
(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [MSG_W-NONCE_W-1:0]   base_msg,
    input  logic [NONCE_W-1:0]         nonce_start,
    input  logic [NONCE_W-1:0]         nonce_end,
    input  logic [DIGEST_W-1:0]        target,
    output logic [MSG_W-1:0]           sha_msg,
    output logic [63:0]                sha_length,
    output logic                       sha_new_msg,
    output logic                       sha_begin,
    input  logic                       sha_complete,
    input  logic [DIGEST_W-1:0]        sha_output,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic                       exhausted,
    output logic                       timed_out,
    output logic [NONCE_W-1:0]         found_nonce,
    output logic [31:0]                hash_count
);

    sweep_state_t               state_q,       state_d;
    logic [MSG_W-NONCE_W-1:0]   base_q,        base_d;
    logic [NONCE_W-1:0]         nonce_q,       nonce_d;
    logic [NONCE_W-1:0]         nonce_end_q,   nonce_end_d;
    logic [DIGEST_W-1:0]        target_q,      target_d;
    logic                       hit_q,         hit_d;
    logic                       exhausted_q,   exhausted_d;
    logic [NONCE_W-1:0]         found_q,       found_d;
    logic [31:0]                hash_count_q,  hash_count_d;
    // Marks the first WAIT cycle, where the core still shows the previous
    // hash's completion level until new_msg has cleared it.
    logic                       first_wait_q,  first_wait_d;
    logic                       digest_hit;

`ifdef NONCE_SWEEP_TIMEOUT_EN
    localparam logic [13:0] WAIT_LAST = 14'(TIMEOUT_CYCLES - 1);
    logic [13:0]                wait_cnt_q,    wait_cnt_d;
    logic                       timed_out_q,   timed_out_d;
`endif

    digest_compare u_digest_compare (
        .digest (sha_output),
        .target (target_q),
        .hit    (digest_hit)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        nonce_d      = nonce_q;
        nonce_end_d  = nonce_end_q;
        target_d     = target_q;
        hit_d        = hit_q;
        exhausted_d  = exhausted_q;
        found_d      = found_q;
        hash_count_d = hash_count_q;
        first_wait_d = first_wait_q;
`ifdef NONCE_SWEEP_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        timed_out_d  = timed_out_q;
`endif

        case (state_q)
            S_IDLE: begin
                // abort has priority over a coincident start
                if (start && !abort) begin
                    base_d       = base_msg;
                    nonce_d      = nonce_start;
                    nonce_end_d  = nonce_end;
                    target_d     = target;
                    hit_d        = 1'b0;
                    exhausted_d  = 1'b0;
                    hash_count_d = '0;
`ifdef NONCE_SWEEP_TIMEOUT_EN
                    timed_out_d  = 1'b0;
`endif
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    first_wait_d = 1'b1;
`ifdef NONCE_SWEEP_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                    state_d      = S_WAIT;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    first_wait_d = 1'b0;
                    if (sha_complete && !first_wait_q) begin
                        state_d = S_CHECK;
                    end
`ifdef NONCE_SWEEP_TIMEOUT_EN
                    else if (wait_cnt_q == WAIT_LAST) begin
                        timed_out_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 14'd1;
                    end
`endif
                end
            end

            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (hash_count_q != 32'hFFFF_FFFF) begin
                        hash_count_d = hash_count_q + 32'd1;
                    end
                    if (digest_hit) begin
                        hit_d   = 1'b1;
                        found_d = nonce_q;
                        state_d = S_DONE;
                    end else if (nonce_q == nonce_end_q) begin
                        exhausted_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        // natural wrap through all-ones to zero
                        nonce_d = nonce_q + {{(NONCE_W-1){1'b0}}, 1'b1};
                        state_d = S_LOAD;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            nonce_q      <= '0;
            nonce_end_q  <= '0;
            target_q     <= '0;
            hit_q        <= 1'b0;
            exhausted_q  <= 1'b0;
            found_q      <= '0;
            hash_count_q <= '0;
            first_wait_q <= 1'b0;
`ifdef NONCE_SWEEP_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timed_out_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            nonce_q      <= nonce_d;
            nonce_end_q  <= nonce_end_d;
            target_q     <= target_d;
            hit_q        <= hit_d;
            exhausted_q  <= exhausted_d;
            found_q      <= found_d;
            hash_count_q <= hash_count_d;
            first_wait_q <= first_wait_d;
`ifdef NONCE_SWEEP_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            timed_out_q  <= timed_out_d;
`endif
        end
    end

    assign sha_msg     = {base_q, nonce_q};
    assign sha_length  = MSG_LEN;
    assign sha_new_msg = (state_q == S_LOAD);
    assign sha_begin   = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                         (state_q == S_CHECK);
    assign done        = (state_q == S_DONE);
    assign hit         = hit_q;
    assign exhausted   = exhausted_q;
    assign found_nonce = found_q;
    assign hash_count  = hash_count_q;
`ifdef NONCE_SWEEP_TIMEOUT_EN
    assign timed_out   = timed_out_q;
`else
    assign timed_out   = 1'b0;
`endif

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_nonce_sweep_controller
// Scoreboard bench: stimulus pushes the expected nonce of every LOAD and the
// expected status of every done pulse; a negedge monitor pops and compares.
// A core stub raises sha_complete 5 cycles after sha_begin with digest
// {~nonce, 224'h0}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nonce_sweep_controller;
    import miner_pkg::*;

    typedef struct {
        logic        hit;
        logic        exh;
        logic        to;
        logic [31:0] found;
        logic [31:0] cnt;
    } done_exp_t;

    logic                     clk = 1'b0;
    logic                     n_rst = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic [MSG_W-NONCE_W-1:0] base_msg = '0;
    logic [NONCE_W-1:0]       nonce_start = '0;
    logic [NONCE_W-1:0]       nonce_end = '0;
    logic [DIGEST_W-1:0]      target = '0;
    logic [MSG_W-1:0]         sha_msg;
    logic [63:0]              sha_length;
    logic                     sha_new_msg, sha_begin;
    logic                     sha_complete = 1'b0;
    logic [DIGEST_W-1:0]      sha_output;
    logic                     busy, done, hit, exhausted, timed_out;
    logic [NONCE_W-1:0]       found_nonce;
    logic [31:0]              hash_count;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [NONCE_W-1:0] exp_nonce[$];
    done_exp_t          exp_done[$];

    // core stub
    logic               stub_en = 1'b1;
    logic [NONCE_W-1:0] stub_nonce = '0;
    int                 stub_cnt = 0;

    localparam logic [DIGEST_W-1:0] TGT_F0 = {32'hFFFF_FFF0, 224'h0};

    nonce_sweep_controller dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .base_msg(base_msg), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .sha_msg(sha_msg), .sha_length(sha_length),
        .sha_new_msg(sha_new_msg), .sha_begin(sha_begin),
        .sha_complete(sha_complete), .sha_output(sha_output),
        .busy(busy), .done(done), .hit(hit), .exhausted(exhausted),
        .timed_out(timed_out), .found_nonce(found_nonce), .hash_count(hash_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sha_begin) begin
            stub_nonce   <= sha_msg[NONCE_W-1:0];
            sha_complete <= 1'b0;
            stub_cnt     <= 5;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1) begin
            stub_cnt <= 0;
            if (stub_en) sha_complete <= 1'b1;
        end
    end
    assign sha_output = {~stub_nonce, 224'h0};

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (n_rst) begin
            if (sha_new_msg) begin
                if (exp_nonce.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    chk("load_nonce", 512'(sha_msg[NONCE_W-1:0]), 512'(exp_nonce.pop_front()));
                    chk("load_base", 512'(sha_msg[MSG_W-1:NONCE_W]), 512'(base_msg));
                    chk("begin_with_new_msg", 512'(sha_begin), 1);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_exp_t e;
                    e = exp_done.pop_front();
                    chk("done_hit", 512'(hit), 512'(e.hit));
                    chk("done_exhausted", 512'(exhausted), 512'(e.exh));
                    chk("done_timed_out", 512'(timed_out), 512'(e.to));
                    chk("done_hash_count", 512'(hash_count), 512'(e.cnt));
                    chk("done_busy", 512'(busy), 0);
                    if (e.hit) chk("done_found_nonce", 512'(found_nonce), 512'(e.found));
                end
            end
        end
    end

    task automatic push_nonces(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) exp_nonce.push_back(s + 32'(i));
    endtask

    task automatic push_done(input logic h, input logic x, input logic t,
                             input logic [31:0] f, input logic [31:0] c);
        done_exp_t e;
        e.hit = h; e.exh = x; e.to = t; e.found = f; e.cnt = c;
        exp_done.push_back(e);
    endtask

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e,
                               input logic [DIGEST_W-1:0] tg);
        @(negedge clk);
        nonce_start = s; nonce_end = e; target = tg;
        base_msg = {13{32'hA5C3_0F1E}} ^ 415'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("new_msg_after_start", 512'(sha_new_msg), 1);
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int loads;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 512'(busy), 0);
        chk("rst_done", 512'(done), 0);
        chk("rst_flags", 512'({hit, exhausted, timed_out}), 0);
        chk("rst_new_msg", 512'({sha_new_msg, sha_begin}), 0);
        chk("rst_msg", 512'(sha_msg), 0);
        chk("rst_length", 512'(sha_length), 447);
        chk("rst_count", 512'({found_nonce, hash_count}), 0);
        n_rst = 1'b1;

        // hit at 0x10 after 7 hashes
        push_nonces(32'h0A, 7);
        push_done(1, 0, 0, 32'h10, 7);
        start_sweep(32'h0A, 32'h20, TGT_F0);
        wait_done(500);
        chk("t1_sticky_hit", 512'({hit, found_nonce}), 512'({1'b1, 32'h10}));

        // exhausted, no hit
        push_nonces(32'h0, 6);
        push_done(0, 1, 0, 0, 6);
        start_sweep(32'h0, 32'h5, TGT_F0);
        wait_done(500);
        chk("t2_sticky_exh", 512'({hit, exhausted, hash_count}), 512'({1'b0, 1'b1, 32'd6}));

        // wrap-around range
        push_nonces(32'hFFFF_FFFE, 4);
        push_done(0, 1, 0, 0, 4);
        start_sweep(32'hFFFF_FFFE, 32'h1, '0);
        wait_done(500);

        // single-nonce range
        push_nonces(32'h40, 1);
        push_done(1, 0, 0, 32'h40, 1);
        start_sweep(32'h40, 32'h40, TGT_F0);
        wait_done(100);

        // abort during third WAIT
        push_nonces(32'h100, 3);
        start_sweep(32'h100, 32'h1FF, '0);
        loads = 1;
        for (int k = 0; k < 100 && loads < 3; k++) begin
            @(negedge clk);
            if (sha_new_msg) loads++;
        end
        chk("abort_reached_third_load", loads, 3);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 512'(busy), 0);
        chk("abort_flags", 512'({hit, exhausted, hash_count}), 512'({2'b00, 32'd2}));
        repeat (10) @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 512'({busy, sha_new_msg}), 0);
        repeat (5) @(negedge clk);

        // core never completes
        stub_en = 1'b0;
        push_nonces(32'h55, 1);
`ifdef NONCE_SWEEP_TIMEOUT_EN
        push_done(0, 0, 1, 0, 0);
        start_sweep(32'h55, 32'h60, TGT_F0);
        t0 = cyc;
        wait_done(20000);
        chk("timeout_latency", cyc - 1 - t0, 16384);
        chk("timeout_sticky", 512'({timed_out, hash_count}), 512'({1'b1, 32'd0}));
`else
        start_sweep(32'h55, 32'h60, TGT_F0);
        t0 = cyc;
        repeat (20000) @(negedge clk);
        chk("no_timeout_busy", 512'({busy, timed_out}), 512'({1'b1, 1'b0}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("no_timeout_abort", 512'(busy), 0);
`endif
        stub_en = 1'b1;

        // reset mid-WAIT
        push_nonces(32'h0, 1);
        start_sweep(32'h0, 32'h5, TGT_F0);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_busy", 512'({busy, done, sha_new_msg}), 0);
        chk("midrst_msg", 512'(sha_msg), 0);
        chk("midrst_status", 512'({hit, exhausted, timed_out, found_nonce, hash_count}), 0);
        chk("midrst_length", 512'(sha_length), 447);
        @(negedge clk);
        n_rst = 1'b1;

        push_nonces(32'h0C, 5);
        push_done(1, 0, 0, 32'h10, 5);
        start_sweep(32'h0C, 32'h30, TGT_F0);
        wait_done(500);

        repeat (3) @(negedge clk);
        chk("nonce_queue_drained", exp_nonce.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
